// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage pipeline controller: opcodes, ALUOp
// codes, the ID/EX control bundle and the halt-drain state encoding.
package ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] HLT    = 7'b1111111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
    logic       halt;
  } ctrl_t;

  // A bubble is a bundle with every enable cleared, so it has no side effects.
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: maps a 7-bit opcode to the control bundle,
// flags undecodable opcodes and reports whether the rs2 field is a source.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_JUMP = 1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       uses_rs2_o
);

  // Truth table of the legacy controller, extended with jump/upper-immediate forms.
  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    illegal_o  = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      R_TYPE: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_R;
        uses_rs2_o      = 1'b1;
      end
      I_TYPE: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_I;
      end
      LW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.aluop    = ALUOP_MEM;
      end
      SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_MEM;
        uses_rs2_o      = 1'b1;
      end
      BR: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.aluop  = ALUOP_BR;
        uses_rs2_o    = 1'b1;
      end
      HLT: begin
        ctrl_o.halt = 1'b1;
      end
      JAL: begin
        if (SUPPORT_JUMP != 0) begin
          ctrl_o.jump     = 1'b1;
          ctrl_o.regwrite = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      JALR: begin
        if (SUPPORT_JUMP != 0) begin
          ctrl_o.jump     = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      LUI, AUIPC: begin
        if (SUPPORT_JUMP != 0) begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.aluop    = ALUOP_MEM;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ID-stage pipeline controller: registers the decoded bundle into ID/EX,
// stalls on load-use hazards, flushes on EX redirects and drains the pipe
// before reporting halted.
module pipeline_ctrl
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int SUPPORT_JUMP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           if_id_instr,
  input  logic                  id_ex_memread_q,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_q,
  input  logic                  ex_redirect,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output ctrl_t                 id_ex_ctrl,
  output logic                  illegal,
  output logic                  halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_t                 dec_ctrl;
  logic                  dec_illegal;
  logic                  dec_uses_rs2;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  hazard;
  logic                  unused_instr;

  ctrl_t                 ctrl_q, ctrl_d;
  logic                  illegal_q, illegal_d;
  logic                  halted_q, halted_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  opcode_decoder #(
    .SUPPORT_JUMP(SUPPORT_JUMP)
  ) u_decoder (
    .opcode_i  (if_id_instr[6:0]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .uses_rs2_o(dec_uses_rs2)
  );

  assign rs1          = if_id_instr[15 +: REG_ADDR_W];
  assign rs2          = if_id_instr[20 +: REG_ADDR_W];
  assign unused_instr = ^if_id_instr;

  assign hazard = id_ex_memread_q && (id_ex_rd_q != '0) &&
                  ((id_ex_rd_q == rs1) || (dec_uses_rs2 && (id_ex_rd_q == rs2)));

  assign id_ex_ctrl = ctrl_q;
  assign illegal    = illegal_q;
  assign halted     = halted_q;

  // Next-state and pipeline steering; redirect beats hazard, hazard beats halt.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    ctrl_d      = dec_ctrl;
    illegal_d   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          ctrl_d      = CTRL_BUBBLE;
        end else if (hazard) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ctrl_d      = CTRL_BUBBLE;
        end else if (dec_illegal) begin
          ctrl_d    = CTRL_BUBBLE;
          illegal_d = 1'b1;
        end else if (dec_ctrl.halt) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ctrl_d      = CTRL_BUBBLE;
          state_d     = DRAIN;
          cnt_d       = CNT_LOAD;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctrl_d      = CTRL_BUBBLE;
        if (cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctrl_d      = CTRL_BUBBLE;
      end
    endcase
    halted_d = halted_q || (state_d == HALTED);
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // ID/EX bundle, illegal pulse, halted flag and drain FSM registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= CTRL_BUBBLE;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      state_q   <= RUN;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed/random bench for pipeline_ctrl with a scoreboard of expected
// ID/EX bundles; a second instance covers SUPPORT_JUMP=0 and DRAIN_CYCLES=1.
module tb_pipeline_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    ctrl_t ctrl;
    logic  ill;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        memread;
  logic [4:0]  exRd;
  logic        redirect;

  logic  pcWrite, ifIdWrite, ifIdFlush, illegalOut, haltedOut;
  ctrl_t idExCtrl;
  logic  pcWrite2, ifIdWrite2, ifIdFlush2, illegalOut2, haltedOut2;
  ctrl_t idExCtrl2;

  expect_t sb[$];
  int vecCount  = 0;
  int checkCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(3), .SUPPORT_JUMP(1)) dut (
    .clk(clk), .reset(reset), .if_id_instr(instr),
    .id_ex_memread_q(memread), .id_ex_rd_q(exRd), .ex_redirect(redirect),
    .pc_write(pcWrite), .if_id_write(ifIdWrite), .if_id_flush(ifIdFlush),
    .id_ex_ctrl(idExCtrl), .illegal(illegalOut), .halted(haltedOut)
  );

  pipeline_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(1), .SUPPORT_JUMP(0)) dut2 (
    .clk(clk), .reset(reset), .if_id_instr(instr),
    .id_ex_memread_q(memread), .id_ex_rd_q(exRd), .ex_redirect(redirect),
    .pc_write(pcWrite2), .if_id_write(ifIdWrite2), .if_id_flush(ifIdFlush2),
    .id_ex_ctrl(idExCtrl2), .illegal(illegalOut2), .halted(haltedOut2)
  );

  function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, op};
  endfunction

  // Reference truth table, written out independently of the design package.
  function automatic ctrl_t refCtrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      7'b0110011: begin c.regwrite = 1; c.aluop = 2'b10; end
      7'b0010011: begin c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b11; end
      7'b0000011: begin c.alusrc = 1; c.memtoreg = 1; c.regwrite = 1; c.memread = 1; end
      7'b0100011: begin c.alusrc = 1; c.memwrite = 1; end
      7'b1100011: begin c.branch = 1; c.aluop = 2'b01; end
      7'b1101111: begin c.jump = 1; c.regwrite = 1; end
      7'b1100111: begin c.jump = 1; c.regwrite = 1; c.alusrc = 1; end
      7'b0110111, 7'b0010111: begin c.regwrite = 1; c.alusrc = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".id_ex_ctrl"}, 16'(idExCtrl), 16'(e.ctrl));
      check({tag, ".illegal"}, 16'(illegalOut), 16'(e.ill));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                               input logic redir, input logic expPc, input logic expIfw,
                               input logic expFlush, input ctrl_t expCtrl, input logic expIll,
                               input string tag);
    expect_t e;
    @(negedge clk);
    instr    = ins;
    memread  = mr;
    exRd     = rd;
    redirect = redir;
    vecCount++;
    #1;
    check({tag, ".pc_write"}, 16'(pcWrite), 16'(expPc));
    check({tag, ".if_id_write"}, 16'(ifIdWrite), 16'(expIfw));
    check({tag, ".if_id_flush"}, 16'(ifIdFlush), 16'(expFlush));
    e.ctrl = expCtrl;
    e.ill  = expIll;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic runNormal(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                           input string tag);
    applyStimulus(ins, mr, rd, 1'b0, 1'b1, 1'b1, 1'b0, refCtrl(ins[6:0]), 1'b0, tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset    = 1'b0;
    instr    = mkInstr(7'b0110011, 5'd1, 5'd2, 5'd3);
    memread  = 1'b0;
    exRd     = 5'd0;
    redirect = 1'b0;
    #1;
    check({tag, ".rst_pc_write"}, 16'(pcWrite), 16'd0);
    check({tag, ".rst_if_id_write"}, 16'(ifIdWrite), 16'd0);
    check({tag, ".rst_if_id_flush"}, 16'(ifIdFlush), 16'd1);
    @(posedge clk);
    #1;
    check({tag, ".rst_id_ex_ctrl"}, 16'(idExCtrl), 16'd0);
    check({tag, ".rst_illegal"}, 16'(illegalOut), 16'd0);
    check({tag, ".rst_halted"}, 16'(haltedOut), 16'd0);
    check({tag, ".rst_halted2"}, 16'(haltedOut2), 16'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [5];
    logic [6:0] op;
    logic [31:0] addInstr;
    logic [31:0] hltInstr;
    ops      = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    addInstr = mkInstr(7'b0110011, 5'd6, 5'd2, 5'd3);
    hltInstr = mkInstr(7'b1111111, 5'd0, 5'd0, 5'd0);
    reset    = 1'b0;
    instr    = '0;
    memread  = 1'b0;
    exRd     = '0;
    redirect = 1'b0;

    doReset("por");

    // Load-use hazards and their non-matching neighbours.
    applyStimulus(mkInstr(7'b0110011, 5'd6, 5'd5, 5'd1), 1, 5'd5, 0, 0, 0, 0, '0, 0, "loaduse_rs1");
    runNormal(mkInstr(7'b0010011, 5'd6, 5'd0, 5'd1), 1, 5'd5, "addi_nostall");
    applyStimulus(mkInstr(7'b0100011, 5'd0, 5'd2, 5'd5), 1, 5'd5, 0, 0, 0, 0, '0, 0, "loaduse_rs2_sw");
    runNormal(mkInstr(7'b0010011, 5'd6, 5'd0, 5'd5), 1, 5'd5, "imm_rs2field_nostall");
    runNormal(mkInstr(7'b0110011, 5'd6, 5'd0, 5'd0), 1, 5'd0, "x0_nostall");

    // Redirect wins over a simultaneous load-use match.
    applyStimulus(mkInstr(7'b1100011, 5'd0, 5'd5, 5'd1), 1, 5'd5, 1, 1, 1, 1, '0, 0, "redirect_over_hazard");
    check("redirect_flush2", 16'(ifIdFlush2), 16'd1);

    // Illegal opcode gives a one-cycle pulse and a bubble.
    applyStimulus(mkInstr(7'b0001111, 5'd1, 5'd2, 5'd3), 0, 5'd0, 0, 1, 1, 0, '0, 1, "illegal_pulse");
    runNormal(mkInstr(7'b0000011, 5'd7, 5'd1, 5'd0), 0, 5'd0, "lw_after_illegal");

    // Jump/upper-immediate forms; the second instance treats JAL as illegal.
    runNormal(mkInstr(7'b1101111, 5'd1, 5'd0, 5'd0), 0, 5'd0, "jal");
    check("jal_illegal_nojump", 16'(illegalOut2), 16'd1);
    check("jal_bubble_nojump", 16'(idExCtrl2), 16'd0);
    runNormal(mkInstr(7'b1100111, 5'd1, 5'd2, 5'd0), 0, 5'd0, "jalr");
    runNormal(mkInstr(7'b0110111, 5'd3, 5'd0, 5'd0), 0, 5'd0, "lui");
    runNormal(mkInstr(7'b0010111, 5'd3, 5'd0, 5'd0), 0, 5'd0, "auipc");

    // Random legacy mix; rd in EX is x0 so no stall can arise.
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 4)];
      runNormal(mkInstr(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31))), 1'($urandom_range(0, 1)), 5'd0, "random_mix");
    end

    // HLT blocked by redirect, then by a hazard: the machine keeps running.
    applyStimulus(hltInstr, 0, 5'd0, 1, 1, 1, 1, '0, 0, "hlt_redirected");
    applyStimulus(mkInstr(7'b1111111, 5'd0, 5'd5, 5'd0), 1, 5'd5, 0, 0, 0, 0, '0, 0, "hlt_hazard");
    runNormal(addInstr, 0, 5'd0, "still_running");

    // Reset in the middle of a drain returns to RUN.
    applyStimulus(hltInstr, 0, 5'd0, 0, 0, 0, 0, '0, 0, "hlt_accept_a");
    applyStimulus(addInstr, 0, 5'd0, 0, 0, 0, 0, '0, 0, "drain_a");
    check("drain_a_halted", 16'(haltedOut), 16'd0);
    doReset("mid_drain");
    runNormal(addInstr, 0, 5'd0, "after_reset");

    // Full drain: halted three edges after acceptance (one for the second instance).
    applyStimulus(hltInstr, 0, 5'd0, 0, 0, 0, 0, '0, 0, "hlt_accept_b");
    check("accept_halted", 16'(haltedOut), 16'd0);
    check("accept_halted2", 16'(haltedOut2), 16'd0);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(addInstr, 0, 5'd0, 1'(k % 3 == 0), 0, 0, 0, '0, 0, "drain_halt");
      check("drain_halted", 16'(haltedOut), 16'(k >= 3));
      check("drain_halted2", 16'(haltedOut2), 16'd1);
      check("drain_pc_write2", 16'(pcWrite2), 16'd0);
      check("drain_if_id_write2", 16'(ifIdWrite2), 16'd0);
    end

    doReset("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
